// File: rtl/serial_addsub_n.sv
// rtl/serial_addsub_n.sv - parametrised bit-serial adder/subtractor, LSB first
// Optional zero flag on the final sum: define SERIAL_ADDSUB_ZERO_EN.
module serial_addsub_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             sum_bit,
  output logic             carry_bit,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDSUB_ZERO_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sum_bit_q, sum_bit_d;
  logic             carry_bit_q, carry_bit_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
`ifdef SERIAL_ADDSUB_ZERO_EN
  logic             any_q, any_d;
  logic             zero_q, zero_d;
`endif

  logic accept;
  logic last;
  logic s;
  logic c;

  // A load is honoured in IDLE and in the DONE cycle (back-to-back), never mid-shift.
  assign accept = load && (state_q != S_SHIFT);
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    s = a_q[0] ^ b_q[0] ^ carry_q;
    c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SHIFT;
      S_SHIFT: if (last) state_d = S_DONE;
      S_DONE:  state_d = load ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_bit_d   = sum_bit_q;
    carry_bit_d = carry_bit_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
`ifdef SERIAL_ADDSUB_ZERO_EN
    any_d       = any_q;
    zero_d      = zero_q;
`endif
    if (accept) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_EN
      any_d   = 1'b0;
      zero_d  = 1'b0;
`endif
    end else if (state_q == S_SHIFT) begin
      sum_bit_d   = s;
      carry_bit_d = c;
      carry_d     = c;
      sum_d       = {s, sum_q[WIDTH-1:1]};
      a_d         = a_q >> 1;
      b_d         = b_q >> 1;
      cnt_d       = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDSUB_ZERO_EN
      any_d       = any_q | s;
`endif
      if (last) begin
        ovf_d  = carry_q ^ c;
        cout_d = c;
`ifdef SERIAL_ADDSUB_ZERO_EN
        zero_d = ~(any_q | s);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_bit_q   <= 1'b0;
      carry_bit_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_EN
      any_q       <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_bit_q   <= sum_bit_d;
      carry_bit_q <= carry_bit_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
`ifdef SERIAL_ADDSUB_ZERO_EN
      any_q       <= any_d;
      zero_q      <= zero_d;
`endif
    end
  end

  assign sum_bit   = sum_bit_q;
  assign carry_bit = carry_bit_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
`ifdef SERIAL_ADDSUB_ZERO_EN
  assign zero      = zero_q;
`endif

endmodule
